// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-select resolve pipeline.
package csa_pkg;

  localparam int CSA_WIDTH = 8;
  localparam int CSA_NBLK  = 4;

  // Dual candidates for one block, as produced by the sum-candidate generator.
  typedef struct packed {
    logic [CSA_WIDTH-1:0] sum0;
    logic [CSA_WIDTH-1:0] sum1;
    logic                 co0;
    logic                 co1;
  } csa_cand_t;

  // One resolved block.
  typedef struct packed {
    logic [CSA_WIDTH-1:0] sum;
    logic                 carry;
  } csa_res_t;

  localparam int CSA_CAND_W = $bits(csa_cand_t);

  // Pick the candidate matching the incoming carry.
  function automatic csa_res_t csa_sel(input logic r, input csa_cand_t pair);
    csa_res_t res;
    res.sum   = r ? pair.sum1 : pair.sum0;
    res.carry = r ? pair.co1  : pair.co0;
    return res;
  endfunction

endpackage

// File: rtl/csa_select_pipe_if.sv
// Handshake and data bundle between the candidate generator, the resolve pipe and its consumer.
interface csa_select_pipe_if #(
  parameter int WIDTH = 8,
  parameter int NBLK  = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   c_in;
  logic [NBLK*WIDTH-1:0]  s0;
  logic [NBLK*WIDTH-1:0]  s1;
  logic [NBLK-1:0]        co0;
  logic [NBLK-1:0]        co1;
  logic                   out_valid;
  logic                   out_ready;
  logic [NBLK*WIDTH-1:0]  sum;
  logic                   c_out;

  modport master (
    output in_valid, c_in, s0, s1, co0, co1, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, c_in, s0, s1, co0, co1, out_ready,
    output in_ready, out_valid, sum, c_out
  );
endinterface

// File: rtl/csa_select_stage.sv
// One resolve stage: selects block K from the incoming carry and registers the bundle.
// pipe_i layout (LSB first): resolved sums of blocks 0..K-1, then candidate pairs of blocks K..NBLK-1.
// pipe_o layout (LSB first): resolved sums of blocks 0..K,   then candidate pairs of blocks K+1..NBLK-1.
module csa_select_stage
  import csa_pkg::*;
#(
  parameter int  K    = 0,
  parameter int  NBLK = CSA_NBLK,
  localparam int LO_W = K * CSA_WIDTH,
  localparam int HI_N = NBLK - 1 - K,
  localparam int PIN  = LO_W + (HI_N + 1) * CSA_CAND_W,
  localparam int POUT = LO_W + CSA_WIDTH + HI_N * CSA_CAND_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            valid_o,
  input  logic            ready_i,
  input  logic            carry_i,
  input  logic [PIN-1:0]  pipe_i,
  output logic            carry_o,
  output logic [POUT-1:0] pipe_o
);

  localparam logic [POUT-1:0] LO_MASK = (POUT'(1) << LO_W) - POUT'(1);

  logic            valid_q;
  logic            carry_q;
  logic [POUT-1:0] pipe_q;
  logic [POUT-1:0] pipe_d;
  csa_cand_t       cand;
  csa_res_t        res;

  assign cand = csa_cand_t'(pipe_i[LO_W +: CSA_CAND_W]);
  assign res  = csa_sel(carry_i, cand);

  // Block K's candidate pair collapses to its resolved sum; everything else shifts through unchanged.
  always_comb begin
    pipe_d = (POUT'(pipe_i >> (LO_W + CSA_CAND_W)) << (LO_W + CSA_WIDTH))
           | (POUT'(pipe_i) & LO_MASK)
           | (POUT'(res.sum) << LO_W);
  end

  // A stage can take a new bundle when empty or when its own content leaves this cycle.
  assign ready_o = !valid_q || ready_i;

  // Valid follows the handshake; data loads only on an actual transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      pipe_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        carry_q <= res.carry;
        pipe_q  <= pipe_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign pipe_o  = pipe_q;

endmodule

// File: rtl/csa_select_pipe.sv
// Carry-select resolve pipeline: one block resolved per stage, outputs straight from the last stage.
module csa_select_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int NBLK  = CSA_NBLK
) (
  input logic              clk,
  input logic              rst_n,
  csa_select_pipe_if.slave bus
);

  localparam int CW = CSA_CAND_W;

  logic [NBLK:0]      valid;
  logic [NBLK:0]      carry;
  logic [NBLK*CW-1:0] cand_pack;
  csa_cand_t          cand_tmp;

  // Gather the per-block candidate pairs into stage 0's layout, block 0 in the lowest slot.
  always_comb begin
    cand_pack = '0;
    cand_tmp  = '0;
    for (int b = 0; b < NBLK; b++) begin
      cand_tmp.sum0 = bus.s0[b*WIDTH +: WIDTH];
      cand_tmp.sum1 = bus.s1[b*WIDTH +: WIDTH];
      cand_tmp.co0  = bus.co0[b];
      cand_tmp.co1  = bus.co1[b];
      cand_pack[b*CW +: CW] = cand_tmp;
    end
  end

  assign valid[0] = bus.in_valid;
  assign carry[0] = bus.c_in;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    localparam int PIN  = k * WIDTH + (NBLK - k) * CW;
    localparam int POUT = (k + 1) * WIDTH + (NBLK - 1 - k) * CW;

    logic [PIN-1:0]  pipe_in;
    logic [POUT-1:0] pipe_out;
    // Ready is chained through per-stage scalars so the backward path stays acyclic per signal.
    logic            rdy_up;
    logic            rdy_dn;

    if (k == 0) begin : g_head
      assign pipe_in = cand_pack;
    end else begin : g_body
      assign pipe_in = g_stage[k-1].pipe_out;
    end

    if (k == NBLK - 1) begin : g_tail
      assign rdy_dn = bus.out_ready;
    end else begin : g_mid
      assign rdy_dn = g_stage[k+1].rdy_up;
    end

    csa_select_stage #(
      .K    (k),
      .NBLK (NBLK)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (valid[k]),
      .ready_o (rdy_up),
      .valid_o (valid[k+1]),
      .ready_i (rdy_dn),
      .carry_i (carry[k]),
      .pipe_i  (pipe_in),
      .carry_o (carry[k+1]),
      .pipe_o  (pipe_out)
    );
  end

  assign bus.in_ready  = g_stage[0].rdy_up;
  assign bus.out_valid = valid[NBLK];
  assign bus.c_out     = carry[NBLK];
  assign bus.sum       = g_stage[NBLK-1].pipe_out;

endmodule
